// File: rtl/secuenciador_paso.sv
// Two-beam passage sequencer: classifies A/B beam patterns into inbound/outbound passages.
// Optional dwell timeout enabled by defining SECUENCIADOR_TIMEOUT_EN.
module secuenciador_paso #(
  parameter int TIMEOUT_CICLOS = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic entrada,
  output logic salida,
  output logic error,
  output logic ocupado
);

  typedef enum logic [2:0] {
    IDLE, E1, E2, E3, S1, S2, S3, WAIT_CLR
  } estado_t;

  estado_t    r_estado;
  estado_t    w_siguiente;
  logic [1:0] w_par;
  logic       w_entrada;
  logic       w_salida;
  logic       w_error;
  logic       w_en_curso;
  logic       w_timeout;

  assign w_par      = {sensor_a, sensor_b};
  assign w_en_curso = (r_estado != IDLE) && (r_estado != WAIT_CLR);

`ifdef SECUENCIADOR_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

  logic [CW-1:0] r_cuenta;

  assign w_timeout = w_en_curso && (r_cuenta == CW'(TIMEOUT_CICLOS - 1));

  // Dwell counter restarts whenever the state changes and only runs mid-passage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cuenta <= '0;
    end else if ((w_siguiente != r_estado) || !w_en_curso) begin
      r_cuenta <= '0;
    end else begin
      r_cuenta <= r_cuenta + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0 & (TIMEOUT_CICLOS == 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= IDLE;
    end else begin
      r_estado <= w_siguiente;
    end
  end

  always_comb begin
    w_siguiente = r_estado;
    w_entrada   = 1'b0;
    w_salida    = 1'b0;
    w_error     = 1'b0;
    unique case (r_estado)
      IDLE: begin
        unique case (w_par)
          2'b10: w_siguiente = E1;
          2'b01: w_siguiente = S1;
          2'b11: begin w_siguiente = WAIT_CLR; w_error = 1'b1; end
          default: w_siguiente = IDLE;
        endcase
      end
      E1: begin
        unique case (w_par)
          2'b11: w_siguiente = E2;
          2'b00: w_siguiente = IDLE;
          2'b01: begin w_siguiente = WAIT_CLR; w_error = 1'b1; end
          default: w_siguiente = E1;
        endcase
      end
      E2: begin
        unique case (w_par)
          2'b01: w_siguiente = E3;
          2'b10: w_siguiente = E1;
          2'b00: begin w_siguiente = WAIT_CLR; w_error = 1'b1; end
          default: w_siguiente = E2;
        endcase
      end
      E3: begin
        unique case (w_par)
          2'b00: begin w_siguiente = IDLE; w_entrada = 1'b1; end
          2'b11: w_siguiente = E2;
          2'b10: begin w_siguiente = WAIT_CLR; w_error = 1'b1; end
          default: w_siguiente = E3;
        endcase
      end
      // Outbound states mirror inbound with the beams swapped
      S1: begin
        unique case (w_par)
          2'b11: w_siguiente = S2;
          2'b00: w_siguiente = IDLE;
          2'b10: begin w_siguiente = WAIT_CLR; w_error = 1'b1; end
          default: w_siguiente = S1;
        endcase
      end
      S2: begin
        unique case (w_par)
          2'b10: w_siguiente = S3;
          2'b01: w_siguiente = S1;
          2'b00: begin w_siguiente = WAIT_CLR; w_error = 1'b1; end
          default: w_siguiente = S2;
        endcase
      end
      S3: begin
        unique case (w_par)
          2'b00: begin w_siguiente = IDLE; w_salida = 1'b1; end
          2'b11: w_siguiente = S2;
          2'b01: begin w_siguiente = WAIT_CLR; w_error = 1'b1; end
          default: w_siguiente = S3;
        endcase
      end
      default: begin
        if (w_par == 2'b00) w_siguiente = IDLE;
      end
    endcase

    // A timeout overrides whatever the inputs asked for this cycle
    if (w_timeout) begin
      w_siguiente = WAIT_CLR;
      w_entrada   = 1'b0;
      w_salida    = 1'b0;
      w_error     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entrada <= 1'b0;
      salida  <= 1'b0;
      error   <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      entrada <= w_entrada;
      salida  <= w_salida;
      error   <= w_error;
      ocupado <= (w_siguiente != IDLE);
    end
  end

endmodule

// File: tb/tb_secuenciador_paso.sv
// Testbench for secuenciador_paso: randomized beam patterns against a sequence-table
// reference model, with a queue-based scoreboard checked by an independent monitor.
module tb_secuenciador_paso;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  logic sensor_a;
  logic sensor_b;
  logic entrada;
  logic salida;
  logic error;
  logic ocupado;

  int tests = 0;
  int fails = 0;

  logic [3:0] expQ[$];

  // Reference model: progress 0 = idle, 1..3 = steps along the passage, 4 = waiting for clear
  logic [1:0] seqIn[4];
  logic [1:0] seqOut[4];
  int mP;
  int mDir;
  int mDwell;

  secuenciador_paso #(.TIMEOUT_CICLOS(TO)) dut (
    .clk(clk),
    .reset(reset),
    .sensor_a(sensor_a),
    .sensor_b(sensor_b),
    .entrada(entrada),
    .salida(salida),
    .error(error),
    .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] got, input logic [3:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got {ent,sal,err,ocu}=%b required %b", name, $time, got, want);
    end
  endtask

  function automatic logic [1:0] seqAt(input int idx);
    return (mDir != 0) ? seqOut[idx] : seqIn[idx];
  endfunction

  task automatic modelStep(input logic [1:0] pr, output logic [3:0] e);
    logic ent, sal, err, tmo;
    ent = 1'b0; sal = 1'b0; err = 1'b0;
    if (mP == 0) begin
      if (pr == seqIn[1]) begin mP = 1; mDir = 0; end
      else if (pr == seqOut[1]) begin mP = 1; mDir = 1; end
      else if (pr == 2'b11) begin mP = 4; err = 1'b1; end
      mDwell = 0;
    end else if (mP == 4) begin
      if (pr == 2'b00) mP = 0;
      mDwell = 0;
    end else begin
`ifdef SECUENCIADOR_TIMEOUT_EN
      tmo = (mDwell == TO - 1);
`else
      tmo = 1'b0;
`endif
      if (tmo) begin
        mP = 4; err = 1'b1; mDwell = 0;
      end else if (pr == seqAt(mP)) begin
        mDwell++;
      end else if (mP < 3 && pr == seqAt(mP + 1)) begin
        mP++; mDwell = 0;
      end else if (mP == 3 && pr == 2'b00) begin
        if (mDir == 0) ent = 1'b1; else sal = 1'b1;
        mP = 0; mDwell = 0;
      end else if (pr == seqAt(mP - 1)) begin
        mP--; mDwell = 0;
      end else begin
        mP = 4; err = 1'b1; mDwell = 0;
      end
    end
    e = {ent, sal, err, (mP != 0)};
  endtask

  task automatic applyStimulus(input logic [1:0] pr, input int hold);
    logic [3:0] e;
    repeat (hold) begin
      @(negedge clk);
      {sensor_a, sensor_b} = pr;
      modelStep(pr, e);
      expQ.push_back(e);
    end
  endtask

  task automatic applyPattern(input logic [1:0] pat[$], input int hold);
    foreach (pat[i]) applyStimulus(pat[i], hold);
  endtask

  // Asserts reset between clock edges to exercise the asynchronous clear, then releases with 00
  task automatic doReset();
    @(negedge clk);
    #1 reset = 1'b1;
    #1 checkOutput("asyncReset", {entrada, salida, error, ocupado}, 4'b0000);
    {sensor_a, sensor_b} = 2'b11;
    @(posedge clk);
    #1 checkOutput("resetHeld", {entrada, salida, error, ocupado}, 4'b0000);
    @(negedge clk);
    {sensor_a, sensor_b} = 2'b00;
    reset = 1'b0;
    mP = 0; mDir = 0; mDwell = 0;
  endtask

  // Monitor: compares every presented output cycle against the oldest expected entry
  always begin
    logic [3:0] e;
    @(posedge clk);
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("cycle", {entrada, salida, error, ocupado}, e);
      checkOutput("onehotPulse", {3'b000, $onehot0({entrada, salida, error})}, 4'b0001);
    end
  end

  initial begin
    logic [1:0] pat[$];
    logic [1:0] pr;
    int hold;
    int waited;

    seqIn[0] = 2'b00; seqIn[1] = 2'b10; seqIn[2] = 2'b11; seqIn[3] = 2'b01;
    seqOut[0] = 2'b00; seqOut[1] = 2'b01; seqOut[2] = 2'b11; seqOut[3] = 2'b10;
    mP = 0; mDir = 0; mDwell = 0;

    reset = 1'b1;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    #12 checkOutput("resetState", {entrada, salida, error, ocupado}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    pat = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    applyPattern(pat, 3);
    pat = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    applyPattern(pat, 3);
    pat = '{2'b10, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    applyPattern(pat, 2);
    applyStimulus(2'b11, 3);
    applyStimulus(2'b01, 3);
    applyStimulus(2'b00, 2);
    applyStimulus(2'b10, 10);
    applyStimulus(2'b00, 3);
    applyStimulus(2'b10, 2);
    applyStimulus(2'b11, 2);
    doReset();
    pat = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    applyPattern(pat, 3);

    for (int n = 0; n < 400; n++) begin
      pr = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 12) : $urandom_range(1, 3);
      applyStimulus(pr, hold);
      if ($urandom_range(0, 49) == 0) doReset();
    end
    applyStimulus(2'b00, 3);

    waited = 0;
    while (expQ.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: %0d expected entries left, required 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
